// File: rtl/alu_instruction_sequencer.sv
// ---------------------------------------------------------------------------
// alu_instruction_sequencer
// Program-driven front end for the 8-bit ALU datapath. Holds a loadable
// DEPTH x 20-bit program memory and a program counter, and runs a
// fetch/issue state machine that drives opcode/A/B downstream.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   prog_we/addr/data  program write port (accepted only in IDLE or HALT)
//                      word layout: [19] halt, [18:16] opcode, [15:8] A, [7:0] B
//   start              begin execution at address 0 (IDLE or HALT only)
//   stall              downstream not ready; hold the current issue
//   opcode, a, b       registered instruction fields to the control unit / ALU
//   issue_valid        opcode/a/b carry a valid instruction
//   pc                 address of the instruction being fetched or issued
//   busy               high in FETCH or ISSUE
//   halted             high in HALT
// ---------------------------------------------------------------------------
module alu_instruction_sequencer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [19:0]       prog_data,
    input  logic              start,
    input  logic              stall,
    output logic [2:0]        opcode,
    output logic [7:0]        a,
    output logic [7:0]        b,
    output logic              issue_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    localparam int unsigned WORD_W = 20;
    localparam int unsigned HALT_B = 19;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [WORD_W-1:0]   ir_q, ir_d;
    logic [2:0]          opcode_q, opcode_d;
    logic [7:0]          a_q, a_d;
    logic [7:0]          b_q, b_d;
    logic                issue_valid_q, issue_valid_d;
    logic                busy_q, busy_d;
    logic                halted_q, halted_d;

    logic [WORD_W-1:0]   mem_q [DEPTH];
    logic                mem_we_c;
    logic [WORD_W-1:0]   fetch_word_c;

    // Program memory: writes only land while the sequencer is not running.
    assign mem_we_c     = prog_we && ((state_q == S_IDLE) || (state_q == S_HALT));
    assign fetch_word_c = mem_q[pc_q];

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        opcode_d      = opcode_q;
        a_d           = a_q;
        b_d           = b_q;
        issue_valid_d = issue_valid_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                // Load the outputs on the same edge as IR so the instruction
                // is presented in the first ISSUE cycle; a halt word leaves
                // the previous opcode/a/b untouched.
                ir_d    = fetch_word_c;
                state_d = S_ISSUE;
                if (!fetch_word_c[HALT_B]) begin
                    issue_valid_d = 1'b1;
                    opcode_d      = fetch_word_c[18:16];
                    a_d           = fetch_word_c[15:8];
                    b_d           = fetch_word_c[7:0];
                end
            end
            S_ISSUE: begin
                if (ir_q[HALT_B]) begin
                    state_d       = S_HALT;
                    issue_valid_d = 1'b0;
                end else if (stall) begin
                    issue_valid_d = 1'b1;
                    opcode_d      = ir_q[18:16];
                    a_d           = ir_q[15:8];
                    b_d           = ir_q[7:0];
                end else begin
                    issue_valid_d = 1'b0;
                    pc_d          = pc_q + ADDR_W'(1);
                    state_d       = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d == S_FETCH) || (state_d == S_ISSUE);
        halted_d = (state_d == S_HALT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            ir_q          <= '0;
            opcode_q      <= '0;
            a_q           <= '0;
            b_q           <= '0;
            issue_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            opcode_q      <= opcode_d;
            a_q           <= a_d;
            b_q           <= b_d;
            issue_valid_q <= issue_valid_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
        end
    end

    assign opcode      = opcode_q;
    assign a           = a_q;
    assign b           = b_q;
    assign issue_valid = issue_valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_alu_instruction_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for alu_instruction_sequencer. Stimulus pushes expected issues
// into a scoreboard queue; a negedge monitor pops one entry per consumed
// issue (issue_valid=1, stall=0) and checks fields, downstream result and
// the cycle it appeared in.
// ---------------------------------------------------------------------------
module tb_alu_instruction_sequencer;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic              clk;
    logic              reset;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [19:0]       prog_data;
    logic              start;
    logic              stall;
    logic [2:0]        opcode;
    logic [7:0]        a;
    logic [7:0]        b;
    logic              issue_valid;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;

    alu_instruction_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .stall       (stall),
        .opcode      (opcode),
        .a           (a),
        .b           (b),
        .issue_valid (issue_valid),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        bit         chk_res;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp      = 0;
    int   n_err      = 0;
    int   cyc        = 0;
    int   valid_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required completion", cyc);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, expv, cyc);
        end
    endtask

    // Downstream result register model: opcode 000 = add, 001 = sub.
    function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            3'd0:    alu = x + y;
            3'd1:    alu = x - y;
            default: alu = 8'h00;
        endcase
    endfunction

    task automatic push(input logic [2:0] op, input logic [7:0] xa, input logic [7:0] xb,
                        input logic [7:0] res, input bit cr, input int c);
        exp_t e;
        e.op = op; e.a = xa; e.b = xb; e.res = res; e.chk_res = cr; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset && issue_valid) begin
            valid_seen++;
            if (!stall) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", 32'({opcode, a, b}), 32'hFFFFFFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("issue_fields", 32'({opcode, a, b}), 32'({e.op, e.a, e.b}));
                    chk("issue_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.chk_res) chk("alu_result", 32'(alu(opcode, a, b)), 32'(e.res));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_halt(input int bound, output int hc);
        hc = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (halted) begin
                hc = cyc;
                break;
            end
        end
    endtask

    task automatic write(input logic [ADDR_W-1:0] ad, input logic [19:0] d);
        prog_we = 1'b1; prog_addr = ad; prog_data = d;
        step();
        prog_we = 1'b0;
    endtask

    initial begin
        int t;
        int hc;
        logic [19:0] w;
        logic [19:0] prog [3];
        prog[0] = 20'h00503;
        prog[1] = 20'h10904;
        prog[2] = 20'h80000;

        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; stall = 1'b0;
        step(); step();
        reset = 1'b0;

        // Idle after reset, loading the program with write pulses in between.
        for (int i = 0; i < 5; i++) begin
            prog_we   = (i < 3);
            prog_addr = ADDR_W'(i);
            prog_data = (i < 3) ? prog[i] : 20'h0;
            @(negedge clk);
            chk("idle_outputs", 32'({issue_valid, busy, halted, pc, opcode, a, b}), 32'h0);
            step();
        end
        prog_we = 1'b0;

        // Basic run: two issues then halt.
        valid_seen = 0;
        t = cyc + 1;
        start = 1'b1;
        push(3'd0, 8'h05, 8'h03, 8'h08, 1'b1, t + 1);
        push(3'd1, 8'h09, 8'h04, 8'h05, 1'b1, t + 3);
        step();
        start = 1'b0;
        @(negedge clk);
        chk("fetch_state", 32'({busy, halted, pc, issue_valid}), 32'({1'b1, 1'b0, 4'd0, 1'b0}));
        wait_halt(30, hc);
        chk("halt_cycle_basic", 32'(hc), 32'(t + 6));
        chk("halt_outputs", 32'({busy, issue_valid, pc, opcode, a, b}),
            32'({1'b0, 1'b0, 4'd2, 3'd1, 8'h09, 8'h04}));
        chk("valid_count_basic", 32'(valid_seen), 32'd2);
        step();

        // Same program with the first issue stalled for 3 cycles.
        valid_seen = 0;
        t = cyc + 1;
        start = 1'b1;
        stall = 1'b1;
        push(3'd0, 8'h05, 8'h03, 8'h08, 1'b1, t + 4);
        push(3'd1, 8'h09, 8'h04, 8'h05, 1'b1, t + 6);
        step();
        start = 1'b0;
        while (cyc < t + 4) step();
        stall = 1'b0;
        wait_halt(30, hc);
        chk("halt_cycle_stall", 32'(hc), 32'(t + 9));
        chk("valid_count_stall", 32'(valid_seen), 32'd5);
        step();

        // Wrap-around: 16 non-halt words, memory[0] reissued after pc=15.
        for (int i = 0; i < 16; i++) begin
            w = {1'b0, 3'(i % 8), 8'(i), 8'(16 + i)};
            write(ADDR_W'(i), w);
        end
        t = cyc + 1;
        start = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push(3'(i % 8), 8'(i % 16), 8'(16 + (i % 16)), 8'h00, 1'b0, t + 1 + 2 * i);
        end
        step();
        start = 1'b0;
        // A write while busy must be ignored (would otherwise halt the run).
        write(ADDR_W'(3), 20'h80000);
        while (cyc < t + 34) step();
        stall = 1'b1;
        while (cyc < t + 38) step();
        @(negedge clk);
        chk("stalled_issue", 32'({issue_valid, pc, opcode, a, b}),
            32'({1'b1, 4'd1, 3'd1, 8'h01, 8'h11}));
        chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during the stalled issue.
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        chk("reset_mid_issue", 32'({issue_valid, busy, halted, pc, opcode, a, b}), 32'h0);
        step();

        // Restart after reset: memory survives, runs from address 0.
        write(ADDR_W'(1), 20'h80000);
        t = cyc + 1;
        start = 1'b1;
        push(3'd0, 8'h00, 8'h10, 8'h10, 1'b1, t + 1);
        step();
        start = 1'b0;
        wait_halt(30, hc);
        chk("halt_cycle_restart", 32'(hc), 32'(t + 4));
        step();

        // In HALT: write halt word to memory[0] and start on the same edge.
        valid_seen = 0;
        t = cyc + 1;
        prog_we = 1'b1; prog_addr = '0; prog_data = 20'h80000;
        start = 1'b1;
        step();
        prog_we = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("restart_fetch", 32'({busy, halted, pc}), 32'({1'b1, 1'b0, 4'd0}));
        wait_halt(30, hc);
        chk("halt_cycle_same_edge", 32'(hc), 32'(t + 2));
        chk("valid_count_halt_word", 32'(valid_seen), 32'd0);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
